// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned ByteWidth = 8;
    localparam int unsigned LenWidth  = 16;
    localparam int unsigned WordWidth = 32;

    localparam logic [ByteWidth-1:0] MagicDefault = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StWrite,
        StCsum,
        StDone,
        StErr
    } loader_state_e;

endpackage

// File: rtl/byte_to_word.sv
// Big-endian byte-to-word assembler with byte index and running XOR checksum.
module byte_to_word
    import imem_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 byte_valid_i,
    input  logic [ByteWidth-1:0] byte_i,
    output logic [WordWidth-1:0] word_o,
    output logic                 last_o,
    output logic [ByteWidth-1:0] csum_o
);

    logic [1:0]           idx_q;
    logic [WordWidth-1:0] word_q;
    logic [ByteWidth-1:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= 2'd0;
            word_q <= '0;
            csum_q <= '0;
        end else if (clear_i) begin
            // Word register is left alone so Write_Data keeps its last value.
            idx_q  <= 2'd0;
            csum_q <= '0;
        end else if (byte_valid_i) begin
            idx_q  <= idx_q + 2'd1;
            word_q <= {word_q[WordWidth-ByteWidth-1:0], byte_i};
            csum_q <= csum_q ^ byte_i;
        end
    end

    assign word_o = word_q;
    assign csum_o = csum_q;
    assign last_o = byte_valid_i && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader that fills instruction memory and holds the CPU until a clean frame.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned          DEPTH     = 49,
    parameter logic [WordWidth-1:0] BASE_ADDR = 32'h0,
    parameter logic [ByteWidth-1:0] MAGIC     = MagicDefault,
    parameter int unsigned          TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ByteWidth-1:0] rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [WordWidth-1:0] MemAddr,
    output logic                 MemWrite,
    output logic                 MemRead,
    output logic [WordWidth-1:0] Write_Data,
    output logic                 cpu_hold,
    output logic                 load_done,
    output logic                 load_err
);

    localparam int unsigned          IdleWidth = $clog2(TIMEOUT + 1);
    localparam logic [IdleWidth-1:0] IdleLast  = IdleWidth'(TIMEOUT - 1);

    loader_state_e        state_q, state_d;
    logic [LenWidth-1:0]  len_q, len_d;
    logic [WordWidth-1:0] addr_q, addr_d;
    logic [IdleWidth-1:0] idle_q, idle_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 hold_q, hold_d;
    logic                 rx_ready_q;
    logic                 mem_write_q;

    logic                 accept;
    logic                 timed;
    logic                 start;
    logic                 data_byte;
    logic [LenWidth-1:0]  len_frame;
    logic [WordWidth-1:0] word;
    logic                 word_last;
    logic [ByteWidth-1:0] csum;

    assign accept    = rx_valid && rx_ready_q;
    assign len_frame = {len_q[LenWidth-1:ByteWidth], rx_data};
    assign timed     = (state_q == StLenHi) || (state_q == StLenLo) ||
                       (state_q == StData)  || (state_q == StCsum);

    byte_to_word u_byte_to_word (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (start),
        .byte_valid_i(data_byte),
        .byte_i      (rx_data),
        .word_o      (word),
        .last_o      (word_last),
        .csum_o      (csum)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        addr_d    = addr_q;
        done_d    = done_q;
        err_d     = err_q;
        hold_d    = hold_q;
        start     = 1'b0;
        data_byte = 1'b0;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (accept && (rx_data == MAGIC)) begin
                    state_d = StLenHi;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                    addr_d  = BASE_ADDR;
                    start   = 1'b1;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d   = {rx_data, len_q[ByteWidth-1:0]};
                    state_d = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d = len_frame;
                    if (32'(len_frame) > DEPTH) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end else if (len_frame == '0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    data_byte = 1'b1;
                    if (word_last) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                len_d = len_q - 16'd1;
                if (len_q == 16'd1) begin
                    // Last word: keep the address on it so it never passes the top of memory.
                    state_d = StCsum;
                end else begin
                    addr_d  = addr_q + 32'd4;
                    state_d = StData;
                end
            end
            StCsum: begin
                if (accept) begin
                    if (rx_data == csum) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A byte accepted in the expiring cycle wins over the timeout.
        if (timed && !accept && (idle_q == IdleLast)) begin
            state_d = StErr;
            err_d   = 1'b1;
        end
    end

    always_comb begin
        idle_d = '0;
        if (!accept && (timed || (state_q == StWrite))) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            addr_q      <= BASE_ADDR;
            idle_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            hold_q      <= 1'b1;
            rx_ready_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            idle_q      <= idle_d;
            done_q      <= done_d;
            err_q       <= err_d;
            hold_q      <= hold_d;
            rx_ready_q  <= (state_d != StWrite);
            mem_write_q <= (state_d == StWrite);
        end
    end

    assign rx_ready   = rx_ready_q;
    assign MemAddr    = addr_q;
    assign MemWrite   = mem_write_q;
    assign MemRead    = 1'b0;
    assign Write_Data = word;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard checked by a MemWrite monitor.
module tb_imem_loader;

    localparam int unsigned Timeout = 1024;
    localparam logic [7:0]  Magic   = 8'hA5;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] MemAddr;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Write_Data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    wr_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    imem_loader #(
        .DEPTH    (49),
        .BASE_ADDR(32'h0),
        .MAGIC    (Magic),
        .TIMEOUT  (Timeout)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .MemAddr   (MemAddr),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .Write_Data(Write_Data),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (MemWrite !== 1'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'(MemWrite), 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", MemAddr, e.addr);
                chk("wr_data", Write_Data, e.data);
            end
        end
    end

    // Called at #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        rx_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        waited   = 0;
        while (rx_ready !== 1'b1 && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (rx_ready !== 1'b1) begin
            chk("rx_ready_wait", 32'(rx_ready), 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [31:0] w0, input logic [31:0] w1,
                              input int gap, input logic [7:0] flip);
        logic [7:0]  cs;
        logic [31:0] w;
        wr_t         e;
        cs = 8'h00;
        send_byte(Magic, 0);
        send_byte(8'(n >> 8), 0);
        send_byte(8'(n), 0);
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? w0 : w1;
            e.addr = 32'(4 * i);
            e.data = w;
            sb.push_back(e);
            for (int j = 0; j < 4; j++) begin
                cs = cs ^ w[31-8*j -: 8];
                send_byte(w[31-8*j -: 8], gap);
                if (j == 3 && gap == 0) begin
                    chk("wr_strobe_t1", 32'(MemWrite), 32'd1);
                    chk("wr_ready_low_t1", 32'(rx_ready), 32'd0);
                end
            end
        end
        send_byte(cs ^ flip, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wr_t e;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_addr", MemAddr, 32'h0);
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        chk("rst_memread", 32'(MemRead), 32'd0);
        chk("rst_wdata", Write_Data, 32'h0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(rx_ready), 32'd1);

        // Nominal load; payload XOR of these eight bytes is 0x00.
        send_frame(2, 32'h12345678, 32'h9ABCDEF0, 0, 8'h00);
        chk("nom_done", 32'(load_done), 32'd1);
        chk("nom_hold", 32'(cpu_hold), 32'd0);
        chk("nom_err", 32'(load_err), 32'd0);
        chk("nom_writes", 32'(sb.size()), 32'd0);

        // Bad checksum.
        send_frame(2, 32'h12345678, 32'h9ABCDEF0, 0, 8'h88);
        chk("bad_err", 32'(load_err), 32'd1);
        chk("bad_hold", 32'(cpu_hold), 32'd1);
        chk("bad_done", 32'(load_done), 32'd0);
        chk("bad_writes", 32'(sb.size()), 32'd0);

        // Oversize length.
        send_byte(Magic, 0);
        chk("magic_clears_err", 32'(load_err), 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h32, 0);
        chk("over_err", 32'(load_err), 32'd1);
        chk("over_hold", 32'(cpu_hold), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("over_ready", 32'(rx_ready), 32'd1);

        // Zero length after noise, then reload.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        chk("noise_hold", 32'(cpu_hold), 32'd1);
        chk("noise_done", 32'(load_done), 32'd0);
        send_frame(0, 32'h0, 32'h0, 0, 8'h00);
        chk("zero_done", 32'(load_done), 32'd1);
        chk("zero_hold", 32'(cpu_hold), 32'd0);
        send_byte(Magic, 0);
        chk("reload_hold", 32'(cpu_hold), 32'd1);
        chk("reload_done", 32'(load_done), 32'd0);

        // Continue that frame with gapped payload bytes.
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        e.addr = 32'h0;
        e.data = 32'h11223344;
        sb.push_back(e);
        send_byte(8'h11, 10);
        send_byte(8'h22, 10);
        send_byte(8'h33, 10);
        send_byte(8'h44, 10);
        send_byte(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 10);
        chk("gap_done", 32'(load_done), 32'd1);
        chk("gap_writes", 32'(sb.size()), 32'd0);

        // Timeout after two payload bytes.
        send_byte(Magic, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        repeat (Timeout - 1) @(posedge clk);
        #1;
        chk("to_not_yet", 32'(load_err), 32'd0);
        @(posedge clk);
        #1;
        chk("to_err", 32'(load_err), 32'd1);
        chk("to_hold", 32'(cpu_hold), 32'd1);

        // Reset during the third payload byte.
        send_byte(Magic, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        rx_valid = 1'b1;
        rx_data  = 8'hBE;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(rx_ready), 32'd0);
        chk("mid_rst_memwrite", 32'(MemWrite), 32'd0);
        chk("mid_rst_addr", MemAddr, 32'h0);
        chk("mid_rst_wdata", Write_Data, 32'h0);
        chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
        chk("mid_rst_err", 32'(load_err), 32'd0);
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(2, 32'hCAFEF00D, 32'h01020304, 0, 8'h00);
        chk("post_rst_done", 32'(load_done), 32'd1);
        chk("post_rst_hold", 32'(cpu_hold), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
